// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 input combinations {a,b,c,d} into a
// 4-input device, holds each for SETTLE_CYCLES, captures the response and
// compares it against the golden table EXPECTED.
// Optional feature macro: SWEEP_COMPLEMENT_CHECK_EN -- when defined, also
// counts vectors where out_n is not the complement of out.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        out,
  input  logic        out_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic [4:0]  cmp_err_cnt,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec;
  logic [3:0] cnt;
  logic       mis_hit;
  logic       cmp_hit;
  logic [4:0] mismatch_nxt;
  logic [4:0] cmp_err_nxt;

`ifdef SWEEP_COMPLEMENT_CHECK_EN
  assign cmp_hit = (out_n != ~out);
`else
  // out_n has no function without the complement check.
  logic unused_out_n;
  assign unused_out_n = out_n;
  assign cmp_hit      = 1'b0;
`endif

  // Per-vector verdicts and the counts they would produce if sampled now;
  // at most 16 samples per sweep, so 5 bits never overflow.
  assign mis_hit      = (out != EXPECTED[vec]);
  assign mismatch_nxt = mismatch_cnt + {4'd0, mis_hit};
  assign cmp_err_nxt  = cmp_err_cnt + {4'd0, cmp_hit};

  // The stimulus pins are the vector register itself, so they are registered.
  assign {a, b, c, d} = vec;

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (cnt == 4'd1) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        state_nxt = (vec == 4'd15) ? DONE : SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, vector/settle counters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vec          <= 4'd0;
      cnt          <= 4'd0;
      table_out    <= 16'd0;
      mismatch_cnt <= 5'd0;
      cmp_err_cnt  <= 5'd0;
      pass         <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            vec          <= 4'd0;
            cnt          <= CNT_LOAD;
            table_out    <= 16'd0;
            mismatch_cnt <= 5'd0;
            cmp_err_cnt  <= 5'd0;
            pass         <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          table_out[vec] <= out;
          mismatch_cnt   <= mismatch_nxt;
          cmp_err_cnt    <= cmp_err_nxt;
          if (vec == 4'd15) begin
            // Verdict uses the counts including this final sample so it is
            // already valid while done is high.
            pass <= (mismatch_nxt == 5'd0) && (cmp_err_nxt == 5'd0);
          end else begin
            vec <= vec + 4'd1;
            cnt <= CNT_LOAD;
          end
        end
        DONE: begin
          vec <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: four instances with different
// golden tables, settle lengths and device models share one clock.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start01 = 1'b0;
  logic start3 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: out = a & b, golden F000, settle 1.
  logic a0, b0, c0, d0, busy0, done0, pass0;
  logic [15:0] tab0;
  logic [4:0] mis0, cmp0;
  logic out0;
  assign out0 = a0 & b0;

  // Instance 1: same device, golden F001.
  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] tab1;
  logic [4:0] mis1, cmp1;
  logic out1;
  assign out1 = a1 & b1;

  // Instance 2: out = a, broken complement out_n = out, golden FF00.
  logic a2, b2, c2, d2, busy2, done2, pass2;
  logic [15:0] tab2;
  logic [4:0] mis2, cmp2;

  // Instance 3: out = a & b, golden F000, settle 3.
  logic a3, b3, c3, d3, busy3, done3, pass3;
  logic [15:0] tab3;
  logic [4:0] mis3, cmp3;
  logic out3;
  assign out3 = a3 & b3;

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hF000)) u0 (
    .clk(clk), .rst(rst), .start(start01), .a(a0), .b(b0), .c(c0), .d(d0),
    .out(out0), .out_n(~out0), .busy(busy0), .done(done0), .table_out(tab0),
    .mismatch_cnt(mis0), .cmp_err_cnt(cmp0), .pass(pass0));

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hF001)) u1 (
    .clk(clk), .rst(rst), .start(start01), .a(a1), .b(b1), .c(c1), .d(d1),
    .out(out1), .out_n(~out1), .busy(busy1), .done(done1), .table_out(tab1),
    .mismatch_cnt(mis1), .cmp_err_cnt(cmp1), .pass(pass1));

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hFF00)) u2 (
    .clk(clk), .rst(rst), .start(start01), .a(a2), .b(b2), .c(c2), .d(d2),
    .out(a2), .out_n(a2), .busy(busy2), .done(done2), .table_out(tab2),
    .mismatch_cnt(mis2), .cmp_err_cnt(cmp2), .pass(pass2));

  truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(16'hF000)) u3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .c(c3), .d(d3),
    .out(out3), .out_n(~out3), .busy(busy3), .done(done3), .table_out(tab3),
    .mismatch_cnt(mis3), .cmp_err_cnt(cmp3), .pass(pass3));

  always #5 clk = ~clk;

  // Count done cycles per instance independently of the directed flow.
  int done0_pulses = 0;
  int done3_pulses = 0;
  always @(posedge clk) begin
    if (done0) done0_pulses <= done0_pulses + 1;
    if (done3) done3_pulses <= done3_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on instances 0..2 and follow instance 0 to done; returns the
  // number of edges after the acceptance edge and the count of out-of-order
  // vectors seen on the way.
  task automatic sweep01(output int lat, output int verr);
    lat  = 0;
    verr = 0;
    start01 = 1'b1;
    tick();
    start01 = 1'b0;
    check("busy_after_start", 32'(busy0), 32'd1);
    if ({a0, b0, c0, d0} != 4'd0) verr++;
    while (!done0 && lat < 200) begin
      tick();
      lat++;
      if (lat < 32 && {a0, b0, c0, d0} != 4'(lat / 2)) verr++;
    end
  endtask

  initial begin
    int lat;
    int verr;
    int p;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_abcd", 32'({a0, b0, c0, d0}), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_table", 32'(tab0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);

    // Single-pulse sweep, settle 1: done 32 edges after acceptance.
    sweep01(lat, verr);
    check("lat_s1", 32'(lat), 32'd32);
    check("vec_order", 32'(verr), 32'd0);
    check("done_busy_low", 32'(busy0), 32'd0);
    check("u0_table", 32'(tab0), 32'hF000);
    check("u0_mis", 32'(mis0), 32'd0);
    check("u0_cmp", 32'(cmp0), 32'd0);
    check("u0_pass", 32'(pass0), 32'd1);
    check("u1_table", 32'(tab1), 32'hF000);
    check("u1_mis", 32'(mis1), 32'd1);
    check("u1_pass", 32'(pass1), 32'd0);
    check("u2_table", 32'(tab2), 32'hFF00);
    check("u2_mis", 32'(mis2), 32'd0);
`ifdef SWEEP_COMPLEMENT_CHECK_EN
    check("u2_cmp", 32'(cmp2), 32'd16);
    check("u2_pass", 32'(pass2), 32'd0);
`else
    check("u2_cmp", 32'(cmp2), 32'd0);
    check("u2_pass", 32'(pass2), 32'd1);
`endif
    tick();
    check("done_one_cycle", 32'(done0), 32'd0);
    check("idle_abcd", 32'({a0, b0, c0, d0}), 32'd0);
    check("done0_pulses", 32'(done0_pulses), 32'd1);
    repeat (3) tick();
    check("hold_table", 32'(tab0), 32'hF000);
    check("hold_pass", 32'(pass0), 32'd1);
    check("hold_mis1", 32'(mis1), 32'd1);

    // Settle 3 with start held high: one 64-edge sweep, then a fresh one.
    start3 = 1'b1;
    tick();
    check("u3_busy_start", 32'(busy3), 32'd1);
    lat = 0;
    while (!done3 && lat < 300) begin
      tick();
      lat++;
    end
    check("lat_s3", 32'(lat), 32'd64);
    check("u3_table", 32'(tab3), 32'hF000);
    check("u3_pass", 32'(pass3), 32'd1);
    tick();
    check("u3_idle_busy", 32'(busy3), 32'd0);
    check("u3_pulses1", 32'(done3_pulses), 32'd1);
    tick();
    check("u3_restart_busy", 32'(busy3), 32'd1);
    lat = 0;
    while (!done3 && lat < 300) begin
      tick();
      lat++;
    end
    check("lat_s3_second", 32'(lat), 32'd64);
    start3 = 1'b0;
    tick();
    check("u3_pulses2", 32'(done3_pulses), 32'd2);
    tick();
    check("u3_stays_idle", 32'(busy3), 32'd0);

    // Reset clears held results.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clr_table", 32'(tab0), 32'd0);
    check("rst_clr_mis1", 32'(mis1), 32'd0);
    check("rst_clr_pass", 32'(pass0), 32'd0);
    check("rst_clr_table3", 32'(tab3), 32'd0);

    // Reset mid-sweep while vector 7 is settling.
    p = done0_pulses;
    start01 = 1'b1;
    tick();
    start01 = 1'b0;
    repeat (14) tick();
    check("mid_vec7", 32'({a0, b0, c0, d0}), 32'd7);
    check("mid_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_abcd", 32'({a0, b0, c0, d0}), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_table", 32'(tab0), 32'd0);
    repeat (40) tick();
    check("abort_no_done", 32'(done0_pulses - p), 32'd0);

    // Clean sweep after the abort.
    sweep01(lat, verr);
    check("lat_after_abort", 32'(lat), 32'd32);
    check("order_after_abort", 32'(verr), 32'd0);
    check("table_after_abort", 32'(tab0), 32'hF000);
    check("pass_after_abort", 32'(pass0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
